uart_rx_configurable: RTL and testbench

Runtime-variable-rate UART receiver, the parametrised successor to the fixed-format decoder in the UART project.
- Generalised in data width, parity mode and stop-bit count.
- Adds a one-cycle valid strobe, parity and framing error flags, a busy flag, start-glitch rejection and a metastability synchroniser.
- Sits between the board RX pin and byte consumers (7-seg display, loopback TX).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_configurable.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_configurable.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive (and later transmit/loopback) blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_BREAK
  } state_t;

  localparam int PAR_EVEN   = 0;
  localparam int PAR_ODD    = 1;
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line that idles high.
module uart_rx_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Q
);

  logic r_Meta;
  logic r_Sync;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Meta <= 1'b1;
      r_Sync <= 1'b1;
    end else begin
      r_Meta <= i_D;
      r_Sync <= r_Meta;
    end
  end

  assign o_Q = r_Sync;

endmodule

// File: rtl/uart_rx_configurable.sv
// UART receiver with runtime bit period, configurable width/parity/stop bits,
// start-glitch rejection and break handling.
module uart_rx_configurable
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PERIOD_WIDTH = 20,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [PERIOD_WIDTH-1:0] i_Period,
  input  logic                    i_UART_RX,
  output logic [DATA_BITS-1:0]    o_Byte,
  output logic                    o_Valid,
  output logic                    o_Parity_Err,
  output logic                    o_Frame_Err,
  output logic                    o_Busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [PERIOD_WIDTH-1:0] ZERO     = '0;
  localparam logic [PERIOD_WIDTH-1:0] ONE      = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P    = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic                    LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic                    PAR_MODE  = 1'(PARITY_ODD);

  logic                    w_Rx;
  logic [PERIOD_WIDTH-1:0] w_Period_Clamped;
  logic                    w_Mid;
  logic                    w_Bit_End;
  logic                    w_Ferr_Next;

  state_t                  r_State;
  logic [PERIOD_WIDTH-1:0] r_Period;
  logic [PERIOD_WIDTH-1:0] r_Cnt;
  logic [IDX_W-1:0]        r_Idx;
  logic                    r_Stop_Idx;
  logic [DATA_BITS-1:0]    r_Shift;
  logic                    r_Par;
  logic                    r_Perr;
  logic                    r_Ferr;
  logic [DATA_BITS-1:0]    r_Byte;
  logic                    r_Valid;
  logic                    r_Parity_Err;
  logic                    r_Frame_Err;

  uart_rx_sync u_sync (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_D   (i_UART_RX),
    .o_Q   (w_Rx)
  );

  assign w_Period_Clamped = (i_Period < MIN_P) ? MIN_P : i_Period;
  assign w_Mid            = (r_Cnt == ((r_Period - ONE) >> 1));
  assign w_Bit_End        = (r_Cnt == (r_Period - ONE));
  assign w_Ferr_Next      = r_Ferr | ~w_Rx;

  // Frame outputs are loaded on entry to DONE so they are valid alongside the strobe.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State      <= ST_IDLE;
      r_Period     <= MIN_P;
      r_Cnt        <= ZERO;
      r_Idx        <= '0;
      r_Stop_Idx   <= 1'b0;
      r_Shift      <= '0;
      r_Par        <= 1'b0;
      r_Perr       <= 1'b0;
      r_Ferr       <= 1'b0;
      r_Byte       <= '0;
      r_Valid      <= 1'b0;
      r_Parity_Err <= 1'b0;
      r_Frame_Err  <= 1'b0;
    end else begin
      r_Valid <= 1'b0;
      unique case (r_State)
        ST_IDLE: begin
          if (!w_Rx) begin
            r_State    <= ST_START;
            r_Cnt      <= ZERO;
            r_Period   <= w_Period_Clamped;
            r_Idx      <= '0;
            r_Stop_Idx <= 1'b0;
            r_Par      <= 1'b0;
            r_Perr     <= 1'b0;
            r_Ferr     <= 1'b0;
          end
        end
        ST_START: begin
          if (w_Mid) begin
            r_Cnt   <= ZERO;
            r_State <= w_Rx ? ST_IDLE : ST_DATA;
          end else begin
            r_Cnt <= r_Cnt + ONE;
          end
        end
        ST_DATA: begin
          if (w_Bit_End) begin
            r_Cnt   <= ZERO;
            r_Shift <= {w_Rx, r_Shift[DATA_BITS-1:1]};
            r_Par   <= r_Par ^ w_Rx;
            if (r_Idx == LAST_IDX) begin
              r_State <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              r_Idx <= r_Idx + IDX_W'(1);
            end
          end else begin
            r_Cnt <= r_Cnt + ONE;
          end
        end
        ST_PARITY: begin
          if (w_Bit_End) begin
            r_Cnt   <= ZERO;
            r_Perr  <= ((r_Par ^ w_Rx) != PAR_MODE);
            r_State <= ST_STOP;
          end else begin
            r_Cnt <= r_Cnt + ONE;
          end
        end
        ST_STOP: begin
          if (w_Bit_End) begin
            r_Cnt  <= ZERO;
            r_Ferr <= w_Ferr_Next;
            if (r_Stop_Idx == LAST_STOP) begin
              r_State      <= ST_DONE;
              r_Valid      <= 1'b1;
              r_Byte       <= r_Shift;
              r_Parity_Err <= r_Perr;
              r_Frame_Err  <= w_Ferr_Next;
            end else begin
              r_Stop_Idx <= r_Stop_Idx + 1'b1;
            end
          end else begin
            r_Cnt <= r_Cnt + ONE;
          end
        end
        ST_DONE: begin
          r_State <= r_Ferr ? ST_BREAK : ST_IDLE;
        end
        ST_BREAK: begin
          if (w_Rx) begin
            r_State <= ST_IDLE;
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign o_Byte       = r_Byte;
  assign o_Valid      = r_Valid;
  assign o_Parity_Err = r_Parity_Err;
  assign o_Frame_Err  = r_Frame_Err;
  assign o_Busy       = (r_State != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_configurable.sv
// Scoreboard bench for uart_rx_configurable: three configurations (8N1,
// 8E1, 5N2) driven with random frames and compared against a frame-level model.
module tb_uart_rx_configurable;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [19:0] pa, pb, pc;
  logic        rxa, rxb, rxc;
  logic [7:0]  ba, bb;
  logic [4:0]  bc;
  logic        va, vb, vc;
  logic        pea, peb, pec;
  logic        fea, feb, fec;
  logic        busya, busyb, busyc;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   n_sent[3];
  int   n_valid[3];
  int   n_chk;
  int   n_pass;

  uart_rx_configurable #(.DATA_BITS(8)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Period(pa), .i_UART_RX(rxa),
    .o_Byte(ba), .o_Valid(va), .o_Parity_Err(pea), .o_Frame_Err(fea), .o_Busy(busya));

  uart_rx_configurable #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Period(pb), .i_UART_RX(rxb),
    .o_Byte(bb), .o_Valid(vb), .o_Parity_Err(peb), .o_Frame_Err(feb), .o_Busy(busyb));

  uart_rx_configurable #(.DATA_BITS(5), .STOP_BITS(2)) dut_c (
    .i_Clk(clk), .i_Rst(rst), .i_Period(pc), .i_UART_RX(rxc),
    .o_Byte(bc), .o_Valid(vc), .o_Parity_Err(pec), .o_Frame_Err(fec), .o_Busy(busyc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  // Reference model: what a receiver must report for a given transmitted frame.
  function automatic exp_t model(input logic [8:0] data, input int nb, input bit pen,
                                 input bit odd, input logic pbit, input int nstop,
                                 input logic [1:0] stops);
    exp_t e;
    int ones;
    ones = 0;
    e.data = '0;
    for (int i = 0; i < nb; i++) begin
      e.data[i] = data[i];
      if (data[i]) ones++;
    end
    if (pbit) ones++;
    e.perr = pen && ((ones % 2) != (odd ? 1 : 0));
    e.ferr = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) e.ferr = 1'b1;
    return e;
  endfunction

  task automatic set_rx(input int d, input logic v);
    case (d)
      0: rxa = v;
      1: rxb = v;
      default: rxc = v;
    endcase
  endtask

  task automatic hold(input int d, input logic v, input int cycles);
    set_rx(d, v);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input int p, input logic [8:0] data, input int nb,
                            input logic pbit, input int nstop, input logic [1:0] stops);
    int   bitlen;
    bit   pen;
    exp_t e;
    pen    = (d == 1);
    bitlen = (p < 2) ? 2 : p;
    e = model(data, nb, pen, 1'b0, pbit, nstop, stops);
    case (d)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
    n_sent[d]++;
    hold(d, 1'b0, bitlen);
    for (int i = 0; i < nb; i++) hold(d, data[i], bitlen);
    if (pen) hold(d, pbit, bitlen);
    for (int i = 0; i < nstop; i++) hold(d, stops[i], bitlen);
  endtask

  task automatic on_valid(input int d, input logic [8:0] b, input logic pe, input logic fe);
    exp_t e;
    bit   have;
    have = 1'b0;
    e.data = '0; e.perr = 1'b0; e.ferr = 1'b0;
    case (d)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
    endcase
    n_valid[d]++;
    chk($sformatf("valid_expected_dut%0d", d), have, 1);
    if (have) begin
      chk($sformatf("byte_dut%0d", d), b, e.data);
      chk($sformatf("parity_err_dut%0d", d), pe, e.perr);
      chk($sformatf("frame_err_dut%0d", d), fe, e.ferr);
    end
  endtask

  always @(negedge clk) begin
    if (va) on_valid(0, {1'b0, ba}, pea, fea);
    if (vb) on_valid(1, {1'b0, bb}, peb, feb);
    if (vc) on_valid(2, {4'b0, bc}, pec, fec);
  end

  initial begin
    int p;
    int busy_cnt;
    logic [8:0] d9;
    logic [1:0] st;
    n_chk = 0; n_pass = 0;
    n_sent = '{0, 0, 0}; n_valid = '{0, 0, 0};
    rst = 1'b1;
    rxa = 1'b1; rxb = 1'b1; rxc = 1'b1;
    pa = 20'd2; pb = 20'd16; pc = 20'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_byte", ba, 0);
    chk("reset_valid", va, 0);
    chk("reset_perr", pea, 0);
    chk("reset_ferr", fea, 0);
    chk("reset_busy", busya, 0);
    @(posedge clk); #1;

    // 8N1 at the minimum period, short idle gap.
    send_frame(0, 2, 9'h0AA, 8, 1'b0, 1, 2'b11);
    hold(0, 1'b1, 4);
    send_frame(0, 2, 9'h055, 8, 1'b0, 1, 2'b11);
    hold(0, 1'b1, 10);

    for (int i = 0; i < 12; i++) begin
      p  = $urandom_range(12, 2);
      pa = 20'(p);
      d9 = 9'($urandom_range(255, 0));
      st = ($urandom_range(5, 0) == 0) ? 2'b10 : 2'b11;
      send_frame(0, p, d9, 8, 1'b0, 1, st);
      hold(0, 1'b1, p + 4);
    end

    // Parity: even parity with wrong then right parity bit, then random.
    pb = 20'd16;
    send_frame(1, 16, 9'h007, 8, 1'b0, 1, 2'b11);
    hold(1, 1'b1, 20);
    send_frame(1, 16, 9'h007, 8, 1'b1, 1, 2'b11);
    hold(1, 1'b1, 20);
    for (int i = 0; i < 6; i++) begin
      p  = $urandom_range(9, 2);
      pb = 20'(p);
      send_frame(1, p, 9'($urandom_range(255, 0)), 8, 1'($urandom_range(1, 0)), 1, 2'b11);
      hold(1, 1'b1, p + 4);
    end

    // Break: stop bit low and line held low; one errored frame, busy until release.
    pa = 20'd8;
    send_frame(0, 8, 9'h0F0, 8, 1'b0, 1, 2'b00);
    hold(0, 1'b0, 40);
    chk("break_busy_held", busya, 1);
    hold(0, 1'b1, 6);
    chk("break_busy_released", busya, 0);

    // Start glitch must be rejected quickly.
    pa = 20'd10;
    hold(0, 1'b0, 3);
    set_rx(0, 1'b1);
    busy_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (busya) busy_cnt++;
    end
    chk("glitch_busy_seen", (busy_cnt > 0), 1);
    chk("glitch_busy_short", (busy_cnt < 10), 1);
    chk("glitch_idle_after", busya, 0);
    @(posedge clk); #1;

    // Reset during bit 3 of 0x3C aborts the frame.
    pa = 20'd4;
    hold(0, 1'b0, 4);
    hold(0, 1'b0, 4);
    hold(0, 1'b0, 4);
    hold(0, 1'b1, 4);
    hold(0, 1'b1, 2);
    #2 rst = 1'b1;
    #1;
    chk("midreset_byte", ba, 0);
    chk("midreset_valid", va, 0);
    chk("midreset_perr", pea, 0);
    chk("midreset_ferr", fea, 0);
    chk("midreset_busy", busya, 0);
    set_rx(0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hold(0, 1'b1, 6);
    send_frame(0, 4, 9'h03C, 8, 1'b0, 1, 2'b11);
    hold(0, 1'b1, 10);

    // 5N2 with period 0 clamped to 2, then random stops/periods.
    pc = 20'd0;
    send_frame(2, 0, 9'h01F, 5, 1'b0, 2, 2'b11);
    hold(2, 1'b1, 6);
    for (int i = 0; i < 6; i++) begin
      p  = $urandom_range(5, 0);
      pc = 20'(p);
      st = 2'($urandom_range(3, 0));
      send_frame(2, p, 9'($urandom_range(31, 0)), 5, 1'b0, 2, st);
      hold(2, 1'b1, 10);
    end

    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("frames_dut0", n_valid[0], n_sent[0]);
    chk("frames_dut1", n_valid[1], n_sent[1]);
    chk("frames_dut2", n_valid[2], n_sent[2]);
    chk("pending_dut0", q_a.size(), 0);
    chk("pending_dut1", q_b.size(), 0);
    chk("pending_dut2", q_c.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
